// File: rtl/trap_ctrl.sv
// Trap sequencer: arbitrates exceptions, MRET and machine interrupts, strobes the
// CSR file, flushes the pipeline and redirects fetch to the handler or to mepc.
module trap_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        exc_valid,
    input  logic [31:0] exc_cause,
    input  logic [31:0] exc_pc,
    input  logic        mret_valid,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic        irq_ext,
    input  logic        irq_sw,
    input  logic        irq_timer,
    input  logic        csr_mie,
    input  logic [31:0] csr_mie_reg,
    input  logic [1:0]  csr_mtvec_mode,
    input  logic [29:0] csr_mtvec_base,
    input  logic [31:0] csr_mepc,
    output logic        csr_exception,
    output logic [31:0] csr_exception_cause,
    output logic [31:0] csr_exception_pc,
    output logic        csr_mret,
    output logic [2:0]  irq_pending,
    output logic        pipe_flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        trap_busy
);

    // Handshake: redirect_valid rises in REDIR and stays high with redirect_pc
    // stable until redirect_ready is sampled high on a rising clk edge.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRAP  = 2'd1,
        RET   = 2'd2,
        REDIR = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] ext_sync_q;
    logic                   sw_q, timer_q;
    logic                   ext_sync;
    logic [31:0]            cause_q, epc_q, target_q;
    logic [31:0]            cause_d, epc_d, target_d;
    logic                   ext_en, sw_en, timer_en, irq_take;
    logic [31:0]            irq_code, base_addr, irq_target;
    logic                   unused_mie_bits;

    assign unused_mie_bits = ^{csr_mie_reg[31:12], csr_mie_reg[10:8],
                               csr_mie_reg[6:4], csr_mie_reg[2:0]};

    // irq_ext is asynchronous, the other two lines already belong to clk.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ext_sync_q <= '0;
            sw_q       <= 1'b0;
            timer_q    <= 1'b0;
        end else begin
            ext_sync_q <= {ext_sync_q[SYNC_STAGES-2:0], irq_ext};
            sw_q       <= irq_sw;
            timer_q    <= irq_timer;
        end
    end

    assign ext_sync    = ext_sync_q[SYNC_STAGES-1];
    assign irq_pending = {ext_sync, timer_q, sw_q};

    assign ext_en   = ext_sync & csr_mie_reg[11];
    assign sw_en    = sw_q     & csr_mie_reg[3];
    assign timer_en = timer_q  & csr_mie_reg[7];
    assign irq_take = csr_mie & commit_valid & (ext_en | sw_en | timer_en);

    always_comb begin
        irq_code = 32'd7;
        if (ext_en) begin
            irq_code = 32'd11;
        end else if (sw_en) begin
            irq_code = 32'd3;
        end
    end

    assign base_addr  = {csr_mtvec_base, 2'b00};
    // Only mode 1 vectors; modes 2 and 3 fall back to direct.
    assign irq_target = (VECTORED_EN && (csr_mtvec_mode == 2'b01))
                        ? base_addr + {irq_code[29:0], 2'b00}
                        : base_addr;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= IDLE;
            cause_q  <= '0;
            epc_q    <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        target_d = target_q;
        case (state_q)
            IDLE: begin
                if (exc_valid) begin
                    state_d  = TRAP;
                    cause_d  = exc_cause;
                    epc_d    = exc_pc;
                    target_d = base_addr;
                end else if (mret_valid) begin
                    state_d  = RET;
                    target_d = csr_mepc;
                end else if (irq_take) begin
                    state_d  = TRAP;
                    cause_d  = 32'h8000_0000 | irq_code;
                    epc_d    = commit_pc;
                    target_d = irq_target;
                end
            end
            TRAP:    state_d = REDIR;
            RET:     state_d = REDIR;
            REDIR:   if (redirect_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Cause/pc stay visible after TRAP; only the strobe qualifies them.
    assign csr_exception       = (state_q == TRAP);
    assign csr_mret            = (state_q == RET);
    assign pipe_flush          = (state_q == TRAP) || (state_q == RET);
    assign redirect_valid      = (state_q == REDIR);
    assign redirect_pc         = redirect_valid ? target_q : 32'h0;
    assign csr_exception_cause = cause_q;
    assign csr_exception_pc    = epc_q;
    assign trap_busy           = (state_q != IDLE);

endmodule
